// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_seq.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_INC  = 4'd6;
  localparam logic [3:0] ALU_DEC  = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

  // Bit positions inside flags = {err, v, n, z, c}
  localparam int FLAG_C   = 0;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_ERR = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;

  // product is the accumulator after this cycle's step; valid as the answer when done=1
  assign product = prod + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (busy) begin
      prod   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, flag register and accumulator chaining.
// Define ALU_MUL_EN to build the multi-cycle MUL (op 10); otherwise op 10 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output alu_state_e       state_dbg
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  alu_state_e       state, state_nxt;
  logic [WIDTH-1:0] acc, op_a;
  logic [WIDTH-1:0] alu_res, mul_res, load_res;
  logic [4:0]       alu_flags, mul_flags, load_flags;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, alu_err;
  logic             accept, is_mul, mul_done, load;

  // Handshake: a transfer happens on a rising clk edge where valid && ready on that side;
  // the producer holds its payload stable while valid && !ready.
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign op_a      = acc_en ? acc : a;
  assign state_dbg = state;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (op == ALU_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (op_a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    mul_res             = mul_prod[WIDTH-1:0];
    mul_flags           = '0;
    mul_flags[FLAG_C]   = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_N]   = mul_prod[MSB];
    mul_flags[FLAG_Z]   = (mul_prod[WIDTH-1:0] == '0);
  end
`else
  assign is_mul    = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = '0;
    case (op)
      ALU_ADD: begin
        sum     = {1'b0, op_a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[MSB] == b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        sum     = {1'b0, op_a} - {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[MSB] != b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_INC: begin
        sum     = {1'b0, op_a} + ONE;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = alu_res[MSB] && !op_a[MSB];
      end
      ALU_DEC: begin
        sum     = {1'b0, op_a} - ONE;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = !alu_res[MSB] && op_a[MSB];
      end
      ALU_AND:  alu_res = op_a & b;
      ALU_OR:   alu_res = op_a | b;
      ALU_XOR:  alu_res = op_a ^ b;
      ALU_NOT:  alu_res = ~op_a;
      ALU_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[MSB];
      end
      ALU_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      ALU_PASS: alu_res = b;
      default:  alu_err = 1'b1;
    endcase

    // Illegal ops report err only; z stays 0 even though the result is 0
    alu_flags           = '0;
    alu_flags[FLAG_ERR] = alu_err;
    alu_flags[FLAG_C]   = alu_c;
    alu_flags[FLAG_V]   = alu_v;
    alu_flags[FLAG_N]   = alu_res[MSB];
    alu_flags[FLAG_Z]   = !alu_err && (alu_res == '0);
  end

  assign load       = (accept && !is_mul) || mul_done;
  assign load_res   = mul_done ? mul_res : alu_res;
  assign load_flags = mul_done ? mul_flags : alu_flags;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_BUSY;
      ST_BUSY: if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // acc takes the same value as the output register, so the next accepted op sees it with no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      acc       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      flags     <= load_flags;
      acc       <= load_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
